rptr_empty_level: RTL
=====================

// Module: rptr_empty_level
// PURPOSE
//  Read-domain pointer/flag generator for the async FIFO; next generation of the read-pointer/empty block.
//  Adds to Gray pointer + registered empty: read-side fill level, programmable almost-empty, underflow flag.
//  Sits in the read clock domain, fed by the 2-flop-synchronised write pointer; drives RAM read address.
// PARAMETERS
//  ADDR_WIDTH  3  RAM address bits; DEPTH = 2**ADDR_WIDTH entries; pointers are ADDR_WIDTH+1 bits
// PORTS
//  i_rclk         in   1             read clock; sole clock of the block
//  i_rrst_n       in   1             asynchronous, active-low reset
//  i_rinc         in   1             read request; honoured only when o_rempty==0
//  i_rq2_wptr     in   ADDR_WIDTH+1  write Gray pointer, already synchronised into i_rclk
//  i_ae_thresh    in   ADDR_WIDTH+1  almost-empty threshold (entries); quasi-static
//  i_uflow_clr    in   1             clears sticky underflow flag/count (macro builds only)
//  o_rempty       out  1             registered empty flag
//  o_raempty      out  1             registered almost-empty flag
//  o_rlevel       out  ADDR_WIDTH+1  registered entries available, 0..DEPTH
//  o_rptr         out  ADDR_WIDTH+1  registered read Gray pointer (to write-domain sync)
//  o_raddr        out  ADDR_WIDTH    RAM read address = rbin[ADDR_WIDTH-1:0]
//  o_runderflow   out  1             sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (async assert, sync release): rbin=0, o_rptr=0, o_rempty=1, o_raempty=1, o_rlevel=0, o_runderflow=0.
//  - rd_en = i_rinc & ~o_rempty; rbin_next = rbin + rd_en (mod 2**(ADDR_WIDTH+1), natural wrap).
//  - rgray_next = (rbin_next>>1) ^ rbin_next; rbin, o_rptr <= next values each i_rclk edge.
//  - o_raddr combinational from registered rbin; RAM data for current address valid while o_rempty==0.
//  - o_rempty <= (rgray_next == i_rq2_wptr): goes 1 on the edge consuming the last entry, no bubble.
//  - wbin = gray2bin(i_rq2_wptr); level_next = wbin - rbin_next (mod 2**(ADDR_WIDTH+1)); o_rlevel <= level_next.
//  - o_raempty <= (level_next <= i_ae_thresh); thresh >= DEPTH => always 1; thresh=0 => equals o_rempty.
//  - Latency: read or wptr change visible on all flags/level one i_rclk edge later; all flags consistent same cycle.
//  - Level pessimistic by sync latency (never overstates); multi-step wptr jumps handled by Gray->bin conversion.
//  - Wrap: pointer MSB toggles every DEPTH reads; full-scale distance DEPTH yields o_rlevel=DEPTH.
//  - Read while empty: pointer holds, flags unchanged; sets o_runderflow (if enabled).
//  - Simultaneous read + new write seen: level_next = old level - 1 + delta, computed from next values.
//  - Reset mid-operation: all state returns to reset values immediately, regardless of i_rinc.
// CONFIGURATION
//  Macro RPTR_EMPTY_UFLOW_EN:
//  - defined: o_runderflow sets on i_rinc & o_rempty, holds until i_uflow_clr; set wins over clear same cycle;
//    internal 8-bit saturating underflow counter for debug visibility, cleared with flag.
//  - undefined: o_runderflow tied 0, i_uflow_clr ignored, no counter logic; port list identical.
// STRUCTURE
//  - Package fifo_ptr_pkg: functions bin2gray/gray2bin (parametrised width via ADDR_WIDTH+1),
//    typedef for pointer width helper, localparam-free; shared with the write-side block.
//  - Sub-module rptr_level_calc: combinational gray2bin of i_rq2_wptr, level_next, almost-empty compare.
//  - Top holds counter, pointer/flag registers, optional underflow logic.
// TESTING (ADDR_WIDTH=3, DEPTH=8)
//  - Reset: hold i_rrst_n=0 with i_rinc=1 -> o_rempty=1, o_raempty=1, o_rlevel=0, o_rptr=0, o_raddr=0.
//  - Fill: i_rq2_wptr=gray(5)=4'b0111, thresh=2 -> next edge o_rempty=0, o_rlevel=5, o_raempty=0.
//  - Drain: 5 back-to-back reads -> o_rlevel 4,3,2(aempty=1),1,0; o_rempty=1 on 5th-read edge; o_raddr=5.
//  - Wrap: 16 write/read cycles -> o_rptr returns to 0, MSB toggled at read 8, o_rlevel=8 when wptr=rptr^4'b1100.
//  - Underflow (macro on): i_rinc=1 while empty -> pointer unchanged, o_runderflow=1 next edge; i_uflow_clr -> 0.
//  - Underflow (macro off): same stimulus -> o_runderflow stays 0, pointer unchanged.

Source files
------------

// File: rtl/fifo_ptr_pkg.sv
// Gray/binary pointer helpers shared by the read- and write-side FIFO pointer blocks.
// Functions operate on a wide container; callers zero-extend and truncate to their pointer width.
package fifo_ptr_pkg;

  typedef logic [15:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Leading zeros of a zero-extended Gray code decode to zeros, so one width serves all pointers
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rptr_level_calc.sv
// Combinational read-side fill level and almost-empty compare from the synchronised write pointer.
import fifo_ptr_pkg::*;

module rptr_level_calc #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic [ADDR_WIDTH:0] i_rq2_wptr,
  input  logic [ADDR_WIDTH:0] i_rbin_next,
  input  logic [ADDR_WIDTH:0] i_ae_thresh,
  output logic [ADDR_WIDTH:0] o_level_next,
  output logic                o_aempty_next
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] w_wbin;

  assign w_wbin        = PW'(gray2bin(ptr_t'(i_rq2_wptr)));
  // Modular difference: a full-scale distance of DEPTH lands on the MSB, giving level=DEPTH
  assign o_level_next  = w_wbin - i_rbin_next;
  assign o_aempty_next = (o_level_next <= i_ae_thresh);

endmodule

// File: rtl/rptr_empty_level.sv
// Read-domain pointer, empty/almost-empty/level generator for the async FIFO.
// Optional sticky underflow flag and debug counter under macro RPTR_EMPTY_UFLOW_EN.
import fifo_ptr_pkg::*;

module rptr_empty_level #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_rclk,
  input  logic                  i_rrst_n,
  input  logic                  i_rinc,
  input  logic [ADDR_WIDTH:0]   i_rq2_wptr,
  input  logic [ADDR_WIDTH:0]   i_ae_thresh,
  input  logic                  i_uflow_clr,
  output logic                  o_rempty,
  output logic                  o_raempty,
  output logic [ADDR_WIDTH:0]   o_rlevel,
  output logic [ADDR_WIDTH:0]   o_rptr,
  output logic [ADDR_WIDTH-1:0] o_raddr,
  output logic                  o_runderflow
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] r_rbin;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_rlevel;
  logic          r_rempty;
  logic          r_raempty;

  logic          w_rd_en;
  logic [PW-1:0] w_rbin_next;
  logic [PW-1:0] w_rgray_next;
  logic [PW-1:0] w_level_next;
  logic          w_aempty_next;

  assign w_rd_en      = i_rinc & ~r_rempty;
  assign w_rbin_next  = r_rbin + PW'(w_rd_en);
  assign w_rgray_next = PW'(bin2gray(ptr_t'(w_rbin_next)));

  rptr_level_calc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_level_calc (
    .i_rq2_wptr    (i_rq2_wptr),
    .i_rbin_next   (w_rbin_next),
    .i_ae_thresh   (i_ae_thresh),
    .o_level_next  (w_level_next),
    .o_aempty_next (w_aempty_next)
  );

  // Flags and level all derive from next-state values so they stay mutually consistent
  always_ff @(posedge i_rclk or negedge i_rrst_n) begin
    if (!i_rrst_n) begin
      r_rbin    <= '0;
      r_rptr    <= '0;
      r_rlevel  <= '0;
      r_rempty  <= 1'b1;
      r_raempty <= 1'b1;
    end else begin
      r_rbin    <= w_rbin_next;
      r_rptr    <= w_rgray_next;
      r_rlevel  <= w_level_next;
      r_rempty  <= (w_rgray_next == i_rq2_wptr);
      r_raempty <= w_aempty_next;
    end
  end

`ifdef RPTR_EMPTY_UFLOW_EN
  logic       r_uflow;
  logic [7:0] r_uflow_cnt;
  logic       w_uflow_hit;

  assign w_uflow_hit = i_rinc & r_rempty;

  // Set has priority over clear when both occur in the same cycle
  always_ff @(posedge i_rclk or negedge i_rrst_n) begin
    if (!i_rrst_n) begin
      r_uflow     <= 1'b0;
      r_uflow_cnt <= '0;
    end else if (w_uflow_hit) begin
      r_uflow     <= 1'b1;
      r_uflow_cnt <= (r_uflow_cnt == 8'hFF) ? r_uflow_cnt : r_uflow_cnt + 8'd1;
    end else if (i_uflow_clr) begin
      r_uflow     <= 1'b0;
      r_uflow_cnt <= '0;
    end
  end

  assign o_runderflow = r_uflow;
`else
  logic w_unused_uflow_clr;
  assign w_unused_uflow_clr = i_uflow_clr;
  assign o_runderflow       = 1'b0;
`endif

  assign o_rempty  = r_rempty;
  assign o_raempty = r_raempty;
  assign o_rlevel  = r_rlevel;
  assign o_rptr    = r_rptr;
  assign o_raddr   = r_rbin[ADDR_WIDTH-1:0];

endmodule
